// File: rtl/icache_ctrl.sv
// rtl/icache_ctrl.sv - direct-mapped instruction cache controller with 4-word line refill
module icache_ctrl #(
    parameter int INDEX_BITS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [15:0] addr,
    input  logic        abort,
    output logic [15:0] rdata,
    output logic        done,
    output logic        hit,
    output logic        err,
    output logic        busy,
    output logic        icache_req,
    output logic        icache_hit,
    output logic        mem_rd,
    output logic [15:0] mem_addr,
    input  logic [15:0] mem_rdata,
    input  logic        mem_valid
);
    localparam int TAG_BITS = 13 - INDEX_BITS;
    localparam int LINES    = 1 << INDEX_BITS;

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_RESP} state_t;

    state_t               state_q, state_d;
    logic [15:1]          addr_q, addr_d;
    logic [2:0]           iss_cnt_q, iss_cnt_d;
    logic [1:0]           ret_cnt_q, ret_cnt_d;
    logic                 drop_q, drop_d;
    logic                 mem_rd_q, mem_rd_d;
    logic [15:1]          mem_addr_q, mem_addr_d;
    logic [LINES-1:0]     valid_q;
    logic [TAG_BITS-1:0]  tag_q [LINES];
    logic [15:0]          data_q [LINES][4];
    logic [15:0]          buf_q [3];
    logic                 install;

    logic [INDEX_BITS-1:0] req_idx, fill_idx;
    logic [TAG_BITS-1:0]   req_tag, fill_tag;
    logic                  lookup_hit;

    assign req_idx    = addr[3 +: INDEX_BITS];
    assign req_tag    = addr[15 -: TAG_BITS];
    assign fill_idx   = addr_q[3 +: INDEX_BITS];
    assign fill_tag   = addr_q[15 -: TAG_BITS];
    assign lookup_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

    assign busy     = (state_q != S_IDLE);
    assign mem_rd   = mem_rd_q;
    assign mem_addr = {mem_addr_q, 1'b0};

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        iss_cnt_d  = iss_cnt_q;
        ret_cnt_d  = ret_cnt_q;
        drop_d     = drop_q;
        mem_rd_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        install    = 1'b0;
        rdata      = 16'h0000;
        done       = 1'b0;
        hit        = 1'b0;
        err        = 1'b0;
        icache_req = 1'b0;
        icache_hit = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (addr[0]) begin
                        done = 1'b1;
                        err  = 1'b1;
                    end else if (lookup_hit) begin
                        done       = 1'b1;
                        hit        = 1'b1;
                        icache_req = 1'b1;
                        icache_hit = 1'b1;
                        rdata      = data_q[req_idx][addr[2:1]];
                    end else begin
                        // Word 0 is issued from the miss edge so reads land in cycles 1..4.
                        addr_d     = addr[15:1];
                        iss_cnt_d  = 3'd1;
                        ret_cnt_d  = 2'd0;
                        drop_d     = 1'b0;
                        mem_rd_d   = 1'b1;
                        mem_addr_d = {addr[15:3], 2'b00};
                        state_d    = S_FILL;
                    end
                end
            end
            S_FILL: begin
                drop_d = drop_q | abort;
                if (!iss_cnt_q[2]) begin
                    mem_rd_d   = 1'b1;
                    mem_addr_d = {addr_q[15:3], iss_cnt_q[1:0]};
                    iss_cnt_d  = iss_cnt_q + 3'd1;
                end
                if (mem_valid) begin
                    ret_cnt_d = ret_cnt_q + 2'd1;
                    if (ret_cnt_q == 2'd3) begin
                        install = 1'b1;
                        state_d = (drop_q || abort) ? S_IDLE : S_RESP;
                    end
                end
            end
            S_RESP: begin
                done       = 1'b1;
                icache_req = 1'b1;
                rdata      = data_q[fill_idx][addr_q[2:1]];
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            iss_cnt_q  <= '0;
            ret_cnt_q  <= '0;
            drop_q     <= 1'b0;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= '0;
            valid_q    <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            iss_cnt_q  <= iss_cnt_d;
            ret_cnt_q  <= ret_cnt_d;
            drop_q     <= drop_d;
            mem_rd_q   <= mem_rd_d;
            mem_addr_q <= mem_addr_d;
            if (install) begin
                valid_q[fill_idx] <= 1'b1;
            end
        end
    end

    // Arrays are not reset; the last word is taken straight from the bus on install.
    always_ff @(posedge clk) begin
        if (state_q == S_FILL && mem_valid) begin
            for (int i = 0; i < 3; i++) begin
                if (ret_cnt_q == 2'(i)) begin
                    buf_q[i] <= mem_rdata;
                end
            end
        end
        if (install) begin
            tag_q[fill_idx] <= fill_tag;
            for (int w = 0; w < 3; w++) begin
                data_q[fill_idx][w] <= buf_q[w];
            end
            data_q[fill_idx][3] <= mem_rdata;
        end
    end
endmodule

// File: tb/tb_icache_ctrl.sv
// tb/tb_icache_ctrl.sv - randomized bench for icache_ctrl against a line-level cache model
module tb_icache_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [15:0] addr;
    logic        abort;
    logic [15:0] rdata;
    logic        done, hit, err, busy, icache_req, icache_hit;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic [15:0] mem_rdata;
    logic        mem_valid;

    icache_ctrl #(.INDEX_BITS(4)) dut (
        .clk(clk), .rst(rst), .req(req), .addr(addr), .abort(abort),
        .rdata(rdata), .done(done), .hit(hit), .err(err), .busy(busy),
        .icache_req(icache_req), .icache_hit(icache_hit),
        .mem_rd(mem_rd), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .mem_valid(mem_valid)
    );

    always #5 clk = ~clk;

    int          n_vec  = 0;
    int          n_miss = 0;
    int          cyc    = 0;
    int          mem_lat = 1;
    bit          noise_ok = 1'b0;
    logic [15:0] mem [32768];
    bit          mv [16];
    logic [8:0]  mt [16];
    logic [15:0] q_addr [$];
    int          q_due [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // In-order memory with fixed latency per fill; optional noise on mem_valid while idle.
    always @(negedge clk) begin
        mem_valid = 1'b0;
        mem_rdata = 16'($urandom);
        if (q_due.size() > 0 && q_due[0] == cyc) begin
            mem_valid = 1'b1;
            mem_rdata = mem[q_addr[0][15:1]];
            void'(q_addr.pop_front());
            void'(q_due.pop_front());
        end else if (noise_ok && $urandom_range(0, 3) == 0) begin
            mem_valid = 1'b1;
        end
        if (mem_rd) begin
            q_addr.push_back(mem_addr);
            q_due.push_back(cyc + mem_lat);
        end
    end

    task automatic do_req(input logic [15:0] a, input int lat, input int abort_at);
        int          idx;
        logic [8:0]  tg;
        logic [15:0] exp_word;
        idx      = int'(a[6:3]);
        tg       = a[15:7];
        exp_word = mem[a[15:1]];
        @(negedge clk);
        req   = 1'b1;
        addr  = a;
        abort = 1'($urandom_range(0, 1));
        #1;
        if (a[0]) begin
            chk("err_done", 32'(done), 1);
            chk("err_err", 32'(err), 1);
            chk("err_hit", 32'(hit), 0);
            chk("err_ireq", 32'(icache_req), 0);
            chk("err_mrd", 32'(mem_rd), 0);
        end else if (mv[idx] && mt[idx] == tg) begin
            chk("hit_done", 32'(done), 1);
            chk("hit_hit", 32'(hit), 1);
            chk("hit_ireq", 32'(icache_req), 1);
            chk("hit_ihit", 32'(icache_hit), 1);
            chk("hit_err", 32'(err), 0);
            chk("hit_rdata", 32'(rdata), 32'(exp_word));
            chk("hit_mrd", 32'(mem_rd), 0);
            chk("hit_busy", 32'(busy), 0);
        end else begin
            chk("miss_done0", 32'(done), 0);
            chk("miss_ireq0", 32'(icache_req), 0);
            mem_lat  = lat;
            noise_ok = 1'b0;
            for (int k = 1; k <= 5 + lat; k++) begin
                @(negedge clk);
                abort = (k == abort_at) ? 1'b1 :
                        (abort_at == 0 && k == 5 + lat) ? 1'($urandom_range(0, 1)) : 1'b0;
                if (abort_at != 0 && k == 5 + lat) begin
                    req = 1'b0;
                end else begin
                    req  = 1'($urandom_range(0, 1));
                    addr = 16'($urandom);
                end
                #1;
                chk("fill_mrd", 32'(mem_rd), 32'(k <= 4));
                if (k <= 4) chk("fill_maddr", 32'(mem_addr), 32'({a[15:3], 2'(k - 1), 1'b0}));
                if (k < 5 + lat) begin
                    chk("fill_busy", 32'(busy), 1);
                    chk("fill_done", 32'(done), 0);
                end else if (abort_at != 0) begin
                    chk("drop_busy", 32'(busy), 0);
                    chk("drop_done", 32'(done), 0);
                end else begin
                    chk("resp_done", 32'(done), 1);
                    chk("resp_hit", 32'(hit), 0);
                    chk("resp_err", 32'(err), 0);
                    chk("resp_ireq", 32'(icache_req), 1);
                    chk("resp_ihit", 32'(icache_hit), 0);
                    chk("resp_busy", 32'(busy), 1);
                    chk("resp_rdata", 32'(rdata), 32'(exp_word));
                end
            end
            mv[idx]  = 1'b1;
            mt[idx]  = tg;
            noise_ok = 1'b1;
        end
        @(negedge clk);
        req   = 1'b0;
        abort = 1'b0;
        #1;
        chk("idle_done", 32'(done), 0);
        chk("idle_busy", 32'(busy), 0);
    endtask

    initial begin
        logic [15:0] ra;
        int          rl;
        rst = 1'b0;
        req = 1'b0;
        addr = 16'h0000;
        abort = 1'b0;
        mem_rdata = 16'h0000;
        mem_valid = 1'b0;
        for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
        mem[16'h0024 >> 1] = 16'hA5A5;
        for (int i = 0; i < 16; i++) mv[i] = 1'b0;

        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_mrd", 32'(mem_rd), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_ireq", 32'(icache_req), 0);
        rst = 1'b1;

        do_req(16'h0024, 3, 0);
        do_req(16'h0026, 1, 0);
        do_req(16'h00A4, 2, 0);
        do_req(16'h0024, 1, 0);
        do_req(16'h0040, 3, 2);
        do_req(16'h0042, 1, 0);
        do_req(16'h0025, 1, 0);
        do_req(16'h0100, 2, 6);
        do_req(16'h0102, 1, 0);

        // Reset after two returns while the 4th read is still on the bus.
        @(negedge clk);
        req = 1'b1; addr = 16'h0324; abort = 1'b0;
        #1;
        chk("rmid_done0", 32'(done), 0);
        mem_lat  = 1;
        noise_ok = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            req = 1'b0;
            #1;
            chk("rmid_mrd", 32'(mem_rd), 1);
        end
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("rmid_busy", 32'(busy), 0);
        chk("rmid_mrd0", 32'(mem_rd), 0);
        chk("rmid_done", 32'(done), 0);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 16; i++) mv[i] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            chk("late_busy", 32'(busy), 0);
            chk("late_mrd", 32'(mem_rd), 0);
        end
        noise_ok = 1'b1;
        do_req(16'h0024, 2, 0);
        do_req(16'h0024, 1, 0);

        for (int n = 0; n < 300; n++) begin
            ra = 16'($urandom) & 16'h01FE;
            if ($urandom_range(0, 7) == 0) ra[0] = 1'b1;
            rl = $urandom_range(1, 5);
            do_req(ra, rl, ($urandom_range(0, 5) == 0) ? $urandom_range(1, 4 + rl) : 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
